// File: rtl/multicycle_controller.sv
// Main FSM plus ALU/branch decode for a multicycle RV32I datapath; outputs are decoded from the current state.
// Instructions take 3 (branch), 4 (store, ALU, jal, upper) or 5 (load, jalr) cycles from FETCH.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       CmpResult,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       Unsign,
  output logic [2:0] ImmSrc,
  output logic       Illegal,
  output logic       Retire,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SR  = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t state_q, state_d;
  logic   taken;

  // funct7b5 selects sub only for register-register ops; shifts pass it to the datapath directly.
  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  alu_op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010,
      3'b011:  alu_op = ALU_SLT;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = ALU_SR;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    Unsign     = 1'b0;
    ImmSrc     = IMM_I;
    Illegal    = 1'b0;
    Retire     = 1'b0;
    taken      = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut picks up the branch or jal target while the register file is read.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_LOAD) ? IMM_I : IMM_S;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op(funct3, funct7b5);
        Unsign     = (funct3 == 3'b011);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op(funct3, 1'b0);
        Unsign     = (funct3 == 3'b011);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        Retire  = 1'b1;
        // funct3[0] inverts the sense: bne, bge, bgeu.
        case (funct3[2:1])
          2'b00: begin
            ALUControl = ALU_SUB;
            taken      = Zero ^ funct3[0];
          end
          2'b10: begin
            ALUControl = ALU_SLT;
            taken      = CmpResult ^ funct3[0];
          end
          2'b11: begin
            ALUControl = ALU_SLT;
            Unsign     = 1'b1;
            taken      = CmpResult ^ funct3[0];
          end
          default: taken = 1'b0;
        endcase
        PCWrite = taken;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        ImmSrc  = IMM_J;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_UPPER: begin
        ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_U;
        state_d = S_ALUWB;
      end
      S_TRAP: begin
        Illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
    // A cycle with reset high must never commit architectural state.
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      Retire   = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control vectors, a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, CmpResult;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Unsign, Illegal, Retire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$];
  string       tag_q[$];

  multicycle_controller #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .CmpResult(CmpResult), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .Unsign(Unsign),
    .ImmSrc(ImmSrc), .Illegal(Illegal), .Retire(Retire), .State(State)
  );

  always #5 clk = ~clk;

  wire [23:0] dut_vec = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                         ALUSrcA, ALUSrcB, ALUControl, Unsign, ImmSrc, Illegal, Retire};

  function automatic logic [23:0] mk(input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                                     input logic uns, input logic [2:0] imm, input logic ill, ret);
    mk = {st, pcw, adr, mw, irw, rw, rs, sa, sb, alu, uns, imm, ill, ret};
  endfunction

  task automatic chk_eq(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [23:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk_eq(t, dut_vec, e);
    end
  end

  task automatic push(input string tag, input logic [23:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic c);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; CmpResult = c;
  endtask

  // Returns at posedge+1 of the cycle after the last expected vector was checked.
  task automatic drain(input string tag);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 30) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk_eq({tag, "_timeout"}, 24'(exp_q.size()), 24'd0);
      exp_q.delete();
      tag_q.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [23:0] v_fetch();
    v_fetch = mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [23:0] v_decode(input logic [2:0] imm);
    v_decode = mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0, 0);
  endfunction
  function automatic logic [23:0] v_aluwb();
    v_aluwb = mk(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0, 1);
  endfunction

  task automatic r_type(input string tag, input logic [2:0] f3, input logic f7,
                        input logic [2:0] alu, input logic uns);
    drive(7'b0110011, f3, f7, 0, 0);
    push({tag, "_fetch"}, v_fetch());
    push({tag, "_decode"}, v_decode(3'b010));
    push({tag, "_execr"}, mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, uns, 3'b000, 0, 0));
    push({tag, "_aluwb"}, v_aluwb());
    drain(tag);
  endtask

  task automatic i_type(input string tag, input logic [2:0] f3, input logic f7,
                        input logic [2:0] alu, input logic uns);
    drive(7'b0010011, f3, f7, 0, 0);
    push({tag, "_fetch"}, v_fetch());
    push({tag, "_decode"}, v_decode(3'b010));
    push({tag, "_execi"}, mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, uns, 3'b000, 0, 0));
    push({tag, "_aluwb"}, v_aluwb());
    drain(tag);
  endtask

  task automatic branch(input string tag, input logic [2:0] f3, input logic z, input logic c,
                        input logic pcw, input logic [2:0] alu, input logic uns);
    drive(7'b1100011, f3, 0, z, c);
    push({tag, "_fetch"}, v_fetch());
    push({tag, "_decode"}, v_decode(3'b010));
    push({tag, "_branch"}, mk(4'd9, pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, uns, 3'b000, 0, 1));
    drain(tag);
  endtask

  task automatic upper(input string tag, input logic [6:0] o, input logic [1:0] sa);
    drive(o, 3'b000, 0, 0, 0);
    push({tag, "_fetch"}, v_fetch());
    push({tag, "_decode"}, v_decode(3'b010));
    push({tag, "_upper"}, mk(4'd12, 0, 0, 0, 0, 0, 2'b00, sa, 2'b01, 3'b000, 0, 3'b100, 0, 0));
    push({tag, "_aluwb"}, v_aluwb());
    drain(tag);
  endtask

  initial begin
    reset = 1'b1;
    drive(7'b0, 3'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("reset_vec", dut_vec, mk(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 3'b000, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;

    // add x3,x1,x2 = 0x002081B3
    r_type("add", 3'b000, 0, 3'b000, 0);
    r_type("sub", 3'b000, 1, 3'b001, 0);
    r_type("and", 3'b111, 0, 3'b010, 0);
    r_type("sltu", 3'b011, 0, 3'b101, 1);
    i_type("addi_f7", 3'b000, 1, 3'b000, 0);
    i_type("srai", 3'b101, 1, 3'b111, 0);
    i_type("sltiu", 3'b011, 0, 3'b101, 1);

    drive(7'b0000011, 3'b010, 0, 0, 0);
    push("lw_fetch", v_fetch());
    push("lw_decode", v_decode(3'b010));
    push("lw_memadr", mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 3'b000, 0, 0));
    push("lw_memread", mk(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0, 0));
    push("lw_memwb", mk(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0, 1));
    drain("lw");

    drive(7'b0100011, 3'b010, 0, 0, 0);
    push("sw_fetch", v_fetch());
    push("sw_decode", v_decode(3'b010));
    push("sw_memadr", mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 3'b001, 0, 0));
    push("sw_memwrite", mk(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0, 1));
    drain("sw");

    branch("beq_z1", 3'b000, 1, 0, 1, 3'b001, 0);
    branch("bne_z1", 3'b001, 1, 0, 0, 3'b001, 0);
    branch("bltu_c0", 3'b110, 0, 0, 0, 3'b101, 1);
    branch("bge_c0", 3'b101, 0, 0, 1, 3'b101, 0);
    branch("blt_c1", 3'b100, 0, 1, 1, 3'b101, 0);
    branch("f3_010", 3'b010, 1, 1, 0, 3'b000, 0);

    drive(7'b1101111, 3'b000, 0, 0, 0);
    push("jal_fetch", v_fetch());
    push("jal_decode", v_decode(3'b011));
    push("jal_jal", mk(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 3'b011, 0, 0));
    push("jal_aluwb", v_aluwb());
    drain("jal");

    drive(7'b1100111, 3'b000, 0, 0, 0);
    push("jalr_fetch", v_fetch());
    push("jalr_decode", v_decode(3'b010));
    push("jalr_jalr", mk(4'd11, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 3'b000, 0, 0));
    push("jalr_jal", mk(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 3'b011, 0, 0));
    push("jalr_aluwb", v_aluwb());
    drain("jalr");

    upper("lui", 7'b0110111, 2'b11);
    upper("auipc", 7'b0010111, 2'b01);

    // Reset landing in MEMWRITE must suppress the store.
    drive(7'b0100011, 3'b010, 0, 0, 0);
    push("swr_fetch", v_fetch());
    push("swr_decode", v_decode(3'b010));
    push("swr_memadr", mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 3'b001, 0, 0));
    drain("swr");
    reset = 1'b1;
    @(negedge clk);
    chk_eq("swr_state", 24'(State), 24'd5);
    chk_eq("swr_memwrite", 24'(MemWrite), 24'd0);
    @(posedge clk); #1;
    chk_eq("swr_after", 24'(State), 24'd0);
    reset = 1'b0;

    drive(7'b0000000, 3'b000, 0, 0, 0);
    push("trap_fetch", v_fetch());
    push("trap_decode", v_decode(3'b010));
    for (int i = 0; i < 10; i++)
      push($sformatf("trap_%0d", i), mk(4'd13, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 1, 0));
    drain("trap");
    reset = 1'b1;
    @(negedge clk);
    chk_eq("trap_rst_state", 24'(State), 24'd13);
    chk_eq("trap_rst_en", 24'({PCWrite, MemWrite, IRWrite, RegWrite}), 24'd0);
    @(posedge clk); #1;
    chk_eq("trap_rst_after", 24'(State), 24'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("post_trap_fetch", dut_vec, v_fetch());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style main FSM plus ALU and branch decoders that sequence a multicycle RV32I datapath: one shared ALU and one unified instruction/data memory port, with IR, OldPC, Data and ALUOut registers held in the datapath.
- Produces every datapath enable and mux select from the opcode, funct3, funct7[5] and the ALU flags.
- Replaces the single-cycle decode for the multicycle CPU variant.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears FSM to FETCH
- op  in  7  Instr[6:0] from IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU result == 0
- CmpResult  in  1  ALUResult[0] (slt/sltu outcome)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl/sra
- Unsign  out  1  unsigned compare (sltu, bltu, bgeu)
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- Illegal  out  1  high while in TRAP
- Retire  out  1  one-cycle pulse in the last state of each instruction
- State  out  4  current state, for debug

Behaviour:
- States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE, 6 EXECR, 7 EXECI, 8 ALUWB, 9 BRANCH, 10 JAL, 11 JALR, 12 UPPER, 13 TRAP.
- Reset (sync): State = FETCH. At reset and in any unlisted state, every output is 0 except the FETCH outputs driven by the state decode. States 14–15 go to FETCH.
- Signals not listed for a state are 0.
- FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10, PCWrite 1 → DECODE.
- DECODE: ALUSrcA 01, ALUSrcB 01, add, ImmSrc B (precomputes the branch target). Next state by op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 / 0010111 → UPPER
  - other → TRAP
- MEMADR: ALUSrcA 10, ALUSrcB 01, add, ImmSrc I (loads) or S (stores) → MEMREAD (loads) / MEMWRITE (stores).
- MEMREAD: AdrSrc 1, ResultSrc 00 → MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1, Retire → FETCH.
- MEMWRITE: AdrSrc 1, MemWrite 1, Retire → FETCH.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALUControl from funct3 → ALUWB.
  - funct3 000: add, or sub when funct7b5 = 1.
  - 010 slt; 011 slt with Unsign.
- EXECI: ALUSrcA 10, ALUSrcB 01, ImmSrc I → ALUWB.
  - funct3 000 is always add; funct7b5 is ignored except for shifts.
- ALUWB: ResultSrc 00, RegWrite 1, Retire → FETCH.
- BRANCH: ALUSrcA 10, ALUSrcB 00, ResultSrc 00, Retire → FETCH.
  - beq/bne use sub and Zero.
  - blt/bge use slt on CmpResult; bltu/bgeu additionally assert Unsign.
  - taken = beq: Zero; bne: !Zero; blt/bltu: CmpResult; bge/bgeu: !CmpResult.
  - PCWrite = taken. funct3 010/011 → not taken (no trap).
- JALR: ALUSrcA 10, ALUSrcB 01, ImmSrc I, add (ALUOut ← rs1 + imm) → JAL. The datapath clears bit 0 of the target.
- JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite 1, ImmSrc J → ALUWB (rd ← OldPC + 4).
  - The J target is already in ALUOut from DECODE; this holds only when ImmSrc = J in DECODE for op 1101111. Therefore DECODE drives ImmSrc J when op = 1101111 and B otherwise.
- UPPER: ALUSrcB 01, ImmSrc U, add, ALUSrcA 11 (lui) or 01 (auipc) → ALUWB.
- TRAP: Illegal 1; all enables 0; stays in TRAP until reset.
- Latency (cycles, FETCH through the last state):
  - 5: load, jalr
  - 4: store, R-type, I-type, jal, lui, auipc
  - 3: branch
- reset asserted in any state: the next state is FETCH and no write enable is active in that cycle.

Test Plan:
- reset, then add x3,x1,x2 (0x002081B3) → states 0,1,6,8; RegWrite only in ALUWB; Retire pulses once on cycle 4.
- lw (op 0000011) → states 0,1,2,3,4, AdrSrc=1 in 3; sw → 0,1,2,5 with MemWrite=1 only in 5.
- beq with Zero=1 → PCWrite=1 in BRANCH. bltu with CmpResult=0 → PCWrite=0 and Unsign=1.
- jalr → 0,1,11,10,8, PCWrite in JAL. lui → ALUSrcA=11, ImmSrc=100 in UPPER.
- op 0000000 → TRAP, Illegal=1, no enables for 10 cycles; reset → FETCH next cycle.
- reset asserted during MEMWRITE → MemWrite=0 in that cycle, State=0 after the edge.
